// File: rtl/io_port_bank.sv
// io_port_bank: strobed input FIFOs and latched valid/ack output registers on the internal bus.
// Define IO_IRQ_EN to add a registered io_irq output (any FIFO non-empty or any overflow flagged).
module io_port_bank #(
  parameter int WIDTH      = 32,
  parameter int NUM_IN     = 2,
  parameter int NUM_OUT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int PORT_SEL_W = 3
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic [PORT_SEL_W-1:0]     port_sel,
  input  logic                      in_portout,
  input  logic                      out_portin,
  input  logic [WIDTH-1:0]          bus_in,
  output logic [WIDTH-1:0]          bus_out,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]         in_strobe,
  output logic [NUM_IN-1:0]         in_empty,
  output logic [NUM_IN-1:0]         in_full,
  output logic [NUM_IN-1:0]         in_overflow,
  input  logic [NUM_IN-1:0]         ovf_clr,
  output logic [NUM_OUT*WIDTH-1:0]  out_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ack
`ifdef IO_IRQ_EN
  ,
  output logic                      io_irq
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [NUM_IN-1:0]            pop;
  logic [NUM_IN-1:0][WIDTH-1:0] head;
  for (genvar k = 0; k < NUM_IN; k++) begin : g_in
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             prev_q, ovf_q, ovf_d, push, wr_en;
    assign push   = in_strobe[k] & ~prev_q;
    assign pop[k] = in_portout && port_sel == PORT_SEL_W'(k) && cnt_q != '0;
    // a pop in the same edge frees the slot, so a push into a full FIFO still lands
    assign wr_en  = push && (cnt_q != CW'(FIFO_DEPTH) || pop[k]);
    always_comb begin
      wr_d  = wr_q + AW'(wr_en);
      rd_d  = rd_q + AW'(pop[k]);
      cnt_d = cnt_q + CW'(wr_en) - CW'(pop[k]);
      ovf_d = (push & ~wr_en) | (ovf_q & ~ovf_clr[k]);
    end
    always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
        wr_q   <= '0;
        rd_q   <= '0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
        prev_q <= 1'b0;
      end else begin
        wr_q   <= wr_d;
        rd_q   <= rd_d;
        cnt_q  <= cnt_d;
        ovf_q  <= ovf_d;
        prev_q <= in_strobe[k];
      end
    end
    always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_q] <= in_data[k*WIDTH +: WIDTH];
    end
    assign head[k]        = mem_q[rd_q];
    assign in_empty[k]    = cnt_q == '0;
    assign in_full[k]     = cnt_q == CW'(FIFO_DEPTH);
    assign in_overflow[k] = ovf_q;
  end
  always_comb begin
    bus_out = '0;
    for (int i = 0; i < NUM_IN; i++) bus_out = bus_out | (pop[i] ? head[i] : '0);
  end
  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d, wr;
    assign wr = out_portin && port_sel == PORT_SEL_W'(j);
    always_comb begin
      data_d  = wr ? bus_in : data_q;
      valid_d = wr | (valid_q & ~out_ack[j]);
    end
    always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end
    assign out_data[j*WIDTH +: WIDTH] = data_q;
    assign out_valid[j]               = valid_q;
  end
`ifdef IO_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = |(~in_empty) | |in_overflow;
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end
  assign io_irq = irq_q;
`endif
endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed and randomized checks of io_port_bank against a queue-based reference model.
module tb_io_port_bank;
  localparam int W = 32, NI = 2, NO = 2, D = 4, SW = 3;
  logic              clock = 1'b0, clear = 1'b0;
  logic [SW-1:0]     port_sel;
  logic              in_portout, out_portin;
  logic [W-1:0]      bus_in, bus_out;
  logic [NI*W-1:0]   in_data;
  logic [NI-1:0]     in_strobe, in_empty, in_full, in_overflow, ovf_clr;
  logic [NO*W-1:0]   out_data;
  logic [NO-1:0]     out_valid, out_ack;
  logic [W-1:0]      q [NI][$];
  bit                prev [NI];
  bit                ovf [NI];
  logic [W-1:0]      od [NO];
  bit                ov [NO];
  int                nvec = 0, nerr = 0;

  always #5 clock = ~clock;

  io_port_bank #(.WIDTH(W), .NUM_IN(NI), .NUM_OUT(NO), .FIFO_DEPTH(D), .PORT_SEL_W(SW)) dut (
    .clock(clock), .clear(clear), .port_sel(port_sel), .in_portout(in_portout),
    .out_portin(out_portin), .bus_in(bus_in), .bus_out(bus_out), .in_data(in_data),
    .in_strobe(in_strobe), .in_empty(in_empty), .in_full(in_full),
    .in_overflow(in_overflow), .ovf_clr(ovf_clr), .out_data(out_data),
    .out_valid(out_valid), .out_ack(out_ack)
  );

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      q[k].delete();
      prev[k] = 0;
      ovf[k]  = 0;
    end
    for (int j = 0; j < NO; j++) begin
      od[j] = '0;
      ov[j] = 0;
    end
  endtask

  task automatic model_edge();
    bit push;
    for (int k = 0; k < NI; k++) begin
      push = in_strobe[k] && !prev[k];
      if (in_portout && port_sel == k && q[k].size() > 0) void'(q[k].pop_front());
      if (ovf_clr[k]) ovf[k] = 0;
      if (push) begin
        if (q[k].size() < D) q[k].push_back(in_data[k*W +: W]);
        else ovf[k] = 1;
      end
      prev[k] = in_strobe[k];
    end
    for (int j = 0; j < NO; j++) begin
      if (out_portin && port_sel == j) begin
        od[j] = bus_in;
        ov[j] = 1;
      end else if (out_ack[j]) ov[j] = 0;
    end
  endtask

  function automatic logic [W-1:0] exp_bus();
    if (in_portout && port_sel < NI)
      if (q[port_sel].size() > 0) return q[port_sel][0];
    return '0;
  endfunction

  function automatic logic [4*2+NO*W-1:0] exp_state();
    logic [NI-1:0] e, f, o;
    logic [NO-1:0] v;
    logic [NO*W-1:0] d;
    for (int k = 0; k < NI; k++) begin
      e[k] = q[k].size() == 0;
      f[k] = q[k].size() == D;
      o[k] = ovf[k];
    end
    for (int j = 0; j < NO; j++) begin
      v[j] = ov[j];
      d[j*W +: W] = od[j];
    end
    return {e, f, o, v, d};
  endfunction

  task automatic tick();
    @(posedge clock);
    if (!clear) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic idle();
    port_sel = '0; in_portout = 0; out_portin = 0; bus_in = '0;
    in_data = '0; in_strobe = '0; ovf_clr = '0; out_ack = '0;
  endtask

  task automatic pulse(input int k, input logic [W-1:0] v);
    in_data[k*W +: W] = v;
    in_strobe[k] = 1;
    tick();
    in_strobe[k] = 0;
    tick();
  endtask

  task automatic test_reset();
    idle();
    repeat (2) @(posedge clock);
    #1 clear = 1;
    model_reset();
    pulse(0, 32'h1111_0001);
    pulse(0, 32'h1111_0002);
    bus_in = 32'hCAFE_0000; out_portin = 1; port_sel = 0;
    tick();
    out_portin = 0; in_portout = 1;
    #2 clear = 0;
    #1;
    nvec++; if (in_empty !== 2'b11) begin nerr++; $display("FAIL reset_empty got %b exp 11", in_empty); end
    nvec++; if (out_valid !== 2'b00) begin nerr++; $display("FAIL reset_valid got %b exp 00", out_valid); end
    nvec++; if (out_data !== '0) begin nerr++; $display("FAIL reset_data got %h exp 0", out_data); end
    nvec++; if (bus_out !== '0) begin nerr++; $display("FAIL reset_bus got %h exp 0", bus_out); end
    model_reset();
    in_portout = 0;
    tick();
    clear = 1;
  endtask

  task automatic test_capture();
    idle();
    in_data[W-1:0] = 32'h1386_8904;
    in_strobe[0] = 1;
    tick();
    nvec++; if (in_empty[0] !== 1'b0) begin nerr++; $display("FAIL cap_empty got %b exp 0", in_empty[0]); end
    tick(); tick();
    in_strobe[0] = 0;
    tick();
    port_sel = 0; in_portout = 1;
    #1;
    nvec++; if (bus_out !== 32'h1386_8904) begin nerr++; $display("FAIL cap_bus got %h exp 13868904", bus_out); end
    tick();
    in_portout = 0;
    nvec++; if (in_empty[0] !== 1'b1) begin nerr++; $display("FAIL cap_once got %b exp 1", in_empty[0]); end
  endtask

  task automatic test_overflow();
    idle();
    for (int i = 1; i <= 5; i++) pulse(1, W'(i));
    nvec++; if (in_full[1] !== 1'b1 || in_overflow[1] !== 1'b1)
      begin nerr++; $display("FAIL ovf_flags got full=%b ovf=%b exp 1 1", in_full[1], in_overflow[1]); end
    for (int i = 1; i <= 4; i++) begin
      port_sel = 1; in_portout = 1;
      #1;
      nvec++; if (bus_out !== W'(i)) begin nerr++; $display("FAIL ovf_pop got %h exp %h", bus_out, W'(i)); end
      tick();
    end
    in_portout = 0;
    ovf_clr[1] = 1;
    tick();
    ovf_clr[1] = 0;
    nvec++; if (in_overflow[1] !== 1'b0) begin nerr++; $display("FAIL ovf_clr got %b exp 0", in_overflow[1]); end
    nvec++; if ({in_empty, in_full, in_overflow, out_valid, out_data} !== exp_state())
      begin nerr++; $display("FAIL ovf_state got %h exp %h", {in_empty, in_full, in_overflow, out_valid, out_data}, exp_state()); end
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] v [5];
    idle();
    v = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
    for (int i = 0; i < 4; i++) pulse(0, v[i]);
    in_data[W-1:0] = v[4]; in_strobe[0] = 1; port_sel = 0; in_portout = 1;
    #1;
    nvec++; if (bus_out !== v[0]) begin nerr++; $display("FAIL pp_head got %h exp %h", bus_out, v[0]); end
    tick();
    in_strobe[0] = 0;
    nvec++; if (in_overflow[0] !== 1'b0 || in_full[0] !== 1'b1)
      begin nerr++; $display("FAIL pp_flags got ovf=%b full=%b exp 0 1", in_overflow[0], in_full[0]); end
    for (int i = 1; i < 5; i++) begin
      #1;
      nvec++; if (bus_out !== v[i]) begin nerr++; $display("FAIL pp_pop got %h exp %h", bus_out, v[i]); end
      tick();
    end
    in_portout = 0;
    nvec++; if (in_empty[0] !== 1'b1) begin nerr++; $display("FAIL pp_empty got %b exp 1", in_empty[0]); end
  endtask

  task automatic test_output();
    idle();
    bus_in = 32'hDEAD_BEEF; port_sel = 1; out_portin = 1;
    tick();
    nvec++; if (out_data[2*W-1:W] !== 32'hDEAD_BEEF || out_valid[1] !== 1'b1)
      begin nerr++; $display("FAIL out_wr got %h/%b exp deadbeef/1", out_data[2*W-1:W], out_valid[1]); end
    bus_in = 32'h1; out_ack[1] = 1;
    tick();
    nvec++; if (out_data[2*W-1:W] !== 32'h1 || out_valid[1] !== 1'b1)
      begin nerr++; $display("FAIL out_wr_ack got %h/%b exp 1/1", out_data[2*W-1:W], out_valid[1]); end
    out_portin = 0;
    tick();
    out_ack[1] = 0;
    nvec++; if (out_valid[1] !== 1'b0) begin nerr++; $display("FAIL out_ack got %b exp 0", out_valid[1]); end
  endtask

  task automatic test_out_of_range();
    logic [4*2+NO*W-1:0] snap;
    idle();
    pulse(0, 32'h5555_AAAA);
    snap = exp_state();
    port_sel = 5; in_portout = 1; out_portin = 1; bus_in = $urandom;
    #1;
    nvec++; if (bus_out !== '0) begin nerr++; $display("FAIL oor_bus got %h exp 0", bus_out); end
    tick();
    nvec++; if ({in_empty, in_full, in_overflow, out_valid, out_data} !== snap)
      begin nerr++; $display("FAIL oor_state got %h exp %h", {in_empty, in_full, in_overflow, out_valid, out_data}, snap); end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      port_sel   = SW'($urandom_range(0, 7));
      in_portout = ($urandom_range(0, 3) == 0);
      out_portin = ($urandom_range(0, 2) == 0);
      bus_in     = $urandom;
      in_data    = {$urandom, $urandom};
      in_strobe  = NI'($urandom);
      ovf_clr    = {NI{$urandom_range(0, 9) == 0}} & NI'($urandom);
      out_ack    = NO'($urandom);
      #1;
      nvec++; if (bus_out !== exp_bus()) begin nerr++; $display("FAIL rnd_bus cyc %0d got %h exp %h", i, bus_out, exp_bus()); end
      tick();
      nvec++; if ({in_empty, in_full, in_overflow, out_valid, out_data} !== exp_state())
        begin nerr++; $display("FAIL rnd_state cyc %0d got %h exp %h", i, {in_empty, in_full, in_overflow, out_valid, out_data}, exp_state()); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_overflow();
    test_full_push_pop();
    test_output();
    test_out_of_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
